// File: rtl/countdown_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_sequencer
// Purpose  : Loadable down counter with start/pause/abort sequencing. It
//            decrements once every PRESCALE clocks and pulses done for one
//            cycle when the count reaches zero.
// Option   : COUNTDOWN_AUTO_RELOAD_EN - when defined, a terminal decrement
//            reloads the last start value and keeps running instead of
//            returning to IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1   // clocks per decrement, 1..255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  // State encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Prescaler value on which the next clock performs a decrement
  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  logic [1:0]       state;
  logic [7:0]       presc;
  logic             tick;
  logic             last;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg;
`endif

  // Decode the prescaler rollover and the 1 -> 0 terminal decrement
  always_comb begin
    tick = (presc == PRESC_LAST);
    last = (count == CNT_ONE);
  end

  // Status outputs follow the registered state directly
  always_comb begin
    busy   = (state == ST_RUN) || (state == ST_PAUSE);
    paused = (state == ST_PAUSE);
  end

  // Main sequencer: reset > abort > start > pause > decrement
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      presc      <= 8'd0;
      count      <= CNT_ZERO;
      done       <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_reg <= CNT_ZERO;
`endif
    end else if (abort) begin
      state <= ST_IDLE;
      presc <= 8'd0;
      count <= CNT_ZERO;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (load_val != CNT_ZERO) begin
              count      <= load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              reload_reg <= load_val;
`endif
              presc      <= 8'd0;
              state      <= ST_RUN;
            end else begin
              // Zero-length request completes immediately without running
              done <= 1'b1;
            end
          end
        end

        ST_RUN, ST_PAUSE: begin
          if (pause) begin
            // Freeze count and prescaler; this edge is lost to the count
            state <= ST_PAUSE;
          end else begin
            // The resume edge counts as a normal run edge so that each
            // paused clock adds exactly one clock of latency
            state <= ST_RUN;
            if (tick) begin
              presc <= 8'd0;
              if (last) begin
                done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                count <= reload_reg;
`else
                count <= CNT_ZERO;
                state <= ST_IDLE;
`endif
              end else if (count != CNT_ZERO) begin
                count <= count - CNT_ONE;
              end
            end else begin
              presc <= presc + 8'd1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          presc <= 8'd0;
          count <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_sequencer
// Purpose  : Directed self-checking bench for countdown_sequencer. Two
//            instances (PRESCALE=1 and PRESCALE=3) share the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;

  logic [3:0] count1, count3;
  logic       busy1, busy3, paused1, paused3, done1, done3;

  int errors = 0;
  int checks = 0;

  countdown_sequencer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .count(count1), .busy(busy1),
    .paused(paused1), .done(done1)
  );

  countdown_sequencer #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .count(count3), .busy(busy3),
    .paused(paused3), .done(done3)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; load_val = 4'd0; pause = 1'b0; abort = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [6:0] exp;
    do_reset();
    exp = 7'b0000_000;
    checks++;
    if ({count1, busy1, paused1, done1} !== exp) begin
      errors++;
      $display("FAIL reset_p1: got count=%0d busy=%b paused=%b done=%b expected 0/0/0/0",
               count1, busy1, paused1, done1);
    end
    checks++;
    if ({count3, busy3, paused3, done3} !== exp) begin
      errors++;
      $display("FAIL reset_p3: got count=%0d busy=%b paused=%b done=%b expected 0/0/0/0",
               count3, busy3, paused3, done3);
    end
    // Reset while paused mid-run
    start = 1'b1; load_val = 4'd6;
    step();
    start = 1'b0; pause = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; pause = 1'b0;
    checks++;
    if ({count1, busy1, paused1, done1} !== exp) begin
      errors++;
      $display("FAIL reset_midrun: got count=%0d busy=%b paused=%b done=%b expected 0/0/0/0",
               count1, busy1, paused1, done1);
    end
  endtask

  // load 5, PRESCALE=1: 5,4,3,2,1 then 0 with done, then done drops
  task automatic test_basic;
    logic [6:0] exp;
    do_reset();
    start = 1'b1; load_val = 4'd5;
    step();
    start = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      if (i < 5)       exp = {4'(5 - i), 1'b1, 1'b0, 1'b0};
      else if (i == 5) exp = {4'd0, 1'b0, 1'b0, 1'b1};
      else             exp = {4'd0, 1'b0, 1'b0, 1'b0};
      checks++;
      if ({count1, busy1, paused1, done1} !== exp) begin
        errors++;
        $display("FAIL basic[%0d]: got count=%0d busy=%b paused=%b done=%b expected %0d/%b/%b/%b",
                 i, count1, busy1, paused1, done1, exp[6:3], exp[2], exp[1], exp[0]);
      end
      step();
    end
  endtask

  // load 2, PRESCALE=3: each value holds 3 clocks, done 6 clocks after start
  task automatic test_prescale;
    logic [6:0] exp;
    do_reset();
    start = 1'b1; load_val = 4'd2;
    step();
    start = 1'b0;
    for (int j = 0; j <= 7; j++) begin
      if (j < 3)       exp = {4'd2, 1'b1, 1'b0, 1'b0};
      else if (j < 6)  exp = {4'd1, 1'b1, 1'b0, 1'b0};
      else if (j == 6) exp = {4'd0, 1'b0, 1'b0, 1'b1};
      else             exp = {4'd0, 1'b0, 1'b0, 1'b0};
      checks++;
      if ({count3, busy3, paused3, done3} !== exp) begin
        errors++;
        $display("FAIL prescale[%0d]: got count=%0d busy=%b paused=%b done=%b expected %0d/%b/%b/%b",
                 j, count3, busy3, paused3, done3, exp[6:3], exp[2], exp[1], exp[0]);
      end
      step();
    end
  endtask

  // load 4, pause 3 clocks at count=2: done at k+7 instead of k+4
  task automatic test_pause;
    logic [6:0] exp;
    do_reset();
    start = 1'b1; load_val = 4'd4;
    step();
    start = 1'b0;
    step();
    step();
    pause = 1'b1;
    for (int j = 3; j <= 8; j++) begin
      step();
      if (j == 5) pause = 1'b0;
      if (j <= 5)      exp = {4'd2, 1'b1, 1'b1, 1'b0};
      else if (j == 6) exp = {4'd1, 1'b1, 1'b0, 1'b0};
      else if (j == 7) exp = {4'd0, 1'b0, 1'b0, 1'b1};
      else             exp = {4'd0, 1'b0, 1'b0, 1'b0};
      checks++;
      if ({count1, busy1, paused1, done1} !== exp) begin
        errors++;
        $display("FAIL pause[k+%0d]: got count=%0d busy=%b paused=%b done=%b expected %0d/%b/%b/%b",
                 j, count1, busy1, paused1, done1, exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // load 9, abort at count=6, then a normal run of 3
  task automatic test_abort;
    logic [6:0] exp;
    do_reset();
    start = 1'b1; load_val = 4'd9;
    step();
    start = 1'b0;
    step(); step(); step();
    checks++;
    if (count1 !== 4'd6) begin
      errors++;
      $display("FAIL abort_pre: got count=%0d expected 6", count1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({count1, busy1, paused1, done1} !== 7'b0000_000) begin
        errors++;
        $display("FAIL abort_idle[%0d]: got count=%0d busy=%b paused=%b done=%b expected 0/0/0/0",
                 j, count1, busy1, paused1, done1);
      end
      step();
    end
    start = 1'b1; load_val = 4'd3;
    step();
    start = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) exp = {4'(3 - i), 1'b1, 1'b0, 1'b0};
      else       exp = {4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({count1, busy1, paused1, done1} !== exp) begin
        errors++;
        $display("FAIL abort_rerun[%0d]: got count=%0d busy=%b paused=%b done=%b expected %0d/%b/%b/%b",
                 i, count1, busy1, paused1, done1, exp[6:3], exp[2], exp[1], exp[0]);
      end
      step();
    end
  endtask

  // load 0 pulses done without busy; start while busy is ignored
  task automatic test_zero_and_busy_start;
    logic [6:0] exp;
    do_reset();
    start = 1'b1; load_val = 4'd0;
    step();
    start = 1'b0;
    checks++;
    if ({count1, busy1, paused1, done1} !== 7'b0000_001) begin
      errors++;
      $display("FAIL zero_start: got count=%0d busy=%b paused=%b done=%b expected 0/0/0/1",
               count1, busy1, paused1, done1);
    end
    step();
    checks++;
    if ({count1, busy1, paused1, done1} !== 7'b0000_000) begin
      errors++;
      $display("FAIL zero_after: got count=%0d busy=%b paused=%b done=%b expected 0/0/0/0",
               count1, busy1, paused1, done1);
    end
    start = 1'b1; load_val = 4'd5;
    step();
    load_val = 4'd7;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 2) start = 1'b0;
      if (i < 5) exp = {4'(5 - i), 1'b1, 1'b0, 1'b0};
      else       exp = {4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({count1, busy1, paused1, done1} !== exp) begin
        errors++;
        $display("FAIL busy_start[%0d]: got count=%0d busy=%b paused=%b done=%b expected %0d/%b/%b/%b",
                 i, count1, busy1, paused1, done1, exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // Corner edges: start on the done edge, abort and pause on the terminal edge
  task automatic test_terminal_edges;
    do_reset();
    start = 1'b1; load_val = 4'd2;
    step();
    load_val = 4'd3;
    step();
    step();
    checks++;
    if ({count1, busy1, done1} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL start_on_done: got count=%0d busy=%b done=%b expected 0/0/1",
               count1, busy1, done1);
    end
    step();
    start = 1'b0;
    checks++;
    if ({count1, busy1, done1} !== {4'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL start_after_done: got count=%0d busy=%b done=%b expected 3/1/0",
               count1, busy1, done1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b1; load_val = 4'd1;
    step();
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({count1, busy1, paused1, done1} !== 7'b0000_000) begin
      errors++;
      $display("FAIL abort_terminal: got count=%0d busy=%b paused=%b done=%b expected 0/0/0/0",
               count1, busy1, paused1, done1);
    end
    start = 1'b1; load_val = 4'd1;
    step();
    start = 1'b0; pause = 1'b1;
    step();
    pause = 1'b0;
    checks++;
    if ({count1, busy1, paused1, done1} !== {4'd1, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pause_terminal: got count=%0d busy=%b paused=%b done=%b expected 1/1/1/0",
               count1, busy1, paused1, done1);
    end
    step();
    checks++;
    if ({count1, busy1, paused1, done1} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL pause_terminal_resume: got count=%0d busy=%b paused=%b done=%b expected 0/0/0/1",
               count1, busy1, paused1, done1);
    end
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // load 3 with reload: 3,2,1 then 3 with done, repeating until abort
  task automatic test_auto_reload;
    logic [6:0] exp;
    do_reset();
    start = 1'b1; load_val = 4'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp = {4'(3 - (i % 3)), 1'b1, 1'b0, ((i % 3) == 0 && i != 0)};
      checks++;
      if ({count1, busy1, paused1, done1} !== exp) begin
        errors++;
        $display("FAIL reload[%0d]: got count=%0d busy=%b paused=%b done=%b expected %0d/%b/%b/%b",
                 i, count1, busy1, paused1, done1, exp[6:3], exp[2], exp[1], exp[0]);
      end
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({count1, busy1, paused1, done1} !== 7'b0000_000) begin
      errors++;
      $display("FAIL reload_abort: got count=%0d busy=%b paused=%b done=%b expected 0/0/0/0",
               count1, busy1, paused1, done1);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_basic();
    test_prescale();
    test_pause();
    test_abort();
    test_zero_and_busy_start();
    test_terminal_edges();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
